// File: rtl/decoder_regfile.sv
`default_nettype none
// =============================================================================
// decoder_regfile: RV32 instruction field/immediate decoder with 32x32 register
// file (async read, sync write-back, x0 hard-wired to zero, sp reset value).
// Revision: 1.0
// =============================================================================
module decoder_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        Jal,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemData,
  input  logic [31:0] pc,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] imm32,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
  localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
  localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
  localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
  localparam logic [31:0] c_SP_RESET  = 32'h0000_7FFC;

  logic [31:0] r_regs [32];
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [6:0]  w_opcode;
  logic [31:0] w_wb_data;
  logic [31:0] w_imm;

  assign w_opcode = inst[6:0];
  assign w_rd     = inst[11:7];
  assign w_rs1    = inst[19:15];
  assign w_rs2    = inst[24:20];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];

  assign w_wb_data = Jal      ? (pc + 32'd4) :
                     MemtoReg ? MemData      : ALUResult;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= (i == 2) ? c_SP_RESET : 32'h0;
      end
    end else if (RegWrite && (w_rd != 5'd0)) begin
      r_regs[w_rd] <= w_wb_data;
    end
  end

  // No bypass: reads always see the committed array contents.
  assign ReadData1 = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
  assign ReadData2 = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];

  always_comb begin
    w_imm = 32'h0;
    case (w_opcode)
      c_OP_IMM: begin
        if ((inst[14:12] == 3'b001) || (inst[14:12] == 3'b101)) begin
          w_imm = {27'h0, inst[24:20]};
        end else begin
          w_imm = {{20{inst[31]}}, inst[31:20]};
        end
      end
      c_OP_LOAD, c_OP_JALR: w_imm = {{20{inst[31]}}, inst[31:20]};
      c_OP_STORE:  w_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      c_OP_BRANCH: w_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      c_OP_JAL:    w_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      // lui immediate is left unshifted; execute applies the <<12.
      c_OP_LUI:    w_imm = {12'h0, inst[31:12]};
      default:     w_imm = 32'h0;
    endcase
  end

  assign imm32 = w_imm;

endmodule
`default_nettype wire

// File: tb/tb_decoder_regfile.sv
`default_nettype none
// tb_decoder_regfile: directed stimulus, per-cycle comparison against a
// behavioural register-file/immediate model, plus hand-computed literal checks.
module tb_decoder_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        RegWrite, MemtoReg, Jal;
  logic [31:0] ALUResult, MemData, pc;
  logic [31:0] ReadData1, ReadData2, imm32;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  int errors = 0;
  int checks = 0;
  logic model_valid = 1'b0;
  logic [31:0] m_regs [32];

  decoder_regfile dut (
    .clk(clk), .rst(rst), .inst(inst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .Jal(Jal), .ALUResult(ALUResult), .MemData(MemData), .pc(pc),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .imm32(imm32),
    .funct3(funct3), .funct7(funct7)
  );

  always #5 clk = ~clk;

  function automatic int sext(input int raw, input int bits);
    if (raw >= (1 << (bits - 1))) return raw - (1 << bits);
    return raw;
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] x);
    int v;
    v = 0;
    case (x[6:0])
      7'b0010011: v = (x[14:12] == 3'd1 || x[14:12] == 3'd5) ? int'(x[24:20])
                                                              : sext(int'(x[31:20]), 12);
      7'b0000011, 7'b1100111: v = sext(int'(x[31:20]), 12);
      7'b0100011: v = sext(int'(x[31:25]) * 32 + int'(x[11:7]), 12);
      7'b1100011: v = sext(int'(x[31]) * 4096 + int'(x[7]) * 2048 +
                           int'(x[30:25]) * 32 + int'(x[11:8]) * 2, 13);
      7'b1101111: v = sext(int'(x[31]) * (1 << 20) + int'(x[19:12]) * 4096 +
                           int'(x[20]) * 2048 + int'(x[30:21]) * 2, 21);
      7'b0110111: v = int'(x[31:12]);
      default:    v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] mk_r(input int rd, input int rs1, input int rs2);
    return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  // Architectural model: updated on each rising edge from the applied inputs.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= (i == 2) ? 32'h7FFC : 32'h0;
      model_valid <= 1'b1;
    end else if (RegWrite && inst[11:7] != 5'd0) begin
      m_regs[inst[11:7]] <= Jal ? pc + 32'd4 : (MemtoReg ? MemData : ALUResult);
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      cmp("model_rd1", ReadData1, m_regs[inst[19:15]]);
      cmp("model_rd2", ReadData2, m_regs[inst[24:20]]);
      cmp("model_imm", imm32, model_imm(inst));
      cmp("model_f3",  {29'h0, funct3}, {29'h0, inst[14:12]});
      cmp("model_f7",  {25'h0, funct7}, {25'h0, inst[31:25]});
    end
  end

  task automatic apply(input logic r, input logic [31:0] in, input logic we,
                       input logic m2r, input logic j, input logic [31:0] alu,
                       input logic [31:0] md, input logic [31:0] p);
    @(posedge clk);
    #2;
    rst = r; inst = in; RegWrite = we; MemtoReg = m2r; Jal = j;
    ALUResult = alu; MemData = md; pc = p;
    #1;
  endtask

  initial begin
    rst = 1'b1; inst = mk_r(0, 2, 5); RegWrite = 1'b0; MemtoReg = 1'b0; Jal = 1'b0;
    ALUResult = 32'h0; MemData = 32'h0; pc = 32'h0;

    // Reset then read sp and x5
    apply(1'b0, mk_r(0, 2, 5), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("reset_sp", ReadData1, 32'h0000_7FFC);
    cmp("reset_x5", ReadData2, 32'h0);

    // Write/read-back x7
    apply(1'b0, mk_r(7, 0, 0), 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 0, 0);
    apply(1'b0, mk_r(0, 7, 0), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("wr_x7", ReadData1, 32'hDEADBEEF);

    // x0 protection
    apply(1'b0, mk_r(0, 0, 0), 1'b1, 1'b0, 1'b0, 32'h12345678, 0, 0);
    apply(1'b0, mk_r(0, 0, 0), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("x0_zero", ReadData1, 32'h0);

    // Source priority: Jal over MemtoReg, then MemtoReg over ALU
    apply(1'b0, mk_r(1, 0, 0), 1'b1, 1'b1, 1'b1, 32'h0BAD, 32'h0BAD, 32'h100);
    apply(1'b0, mk_r(0, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("jal_pc4", ReadData1, 32'h0000_0104);
    apply(1'b0, mk_r(1, 0, 0), 1'b1, 1'b1, 1'b0, 32'h0BAD, 32'hA5A5A5A5, 32'h100);
    apply(1'b0, mk_r(0, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("mem_src", ReadData1, 32'hA5A5A5A5);
    // RegWrite low blocks writes regardless of Jal/MemtoReg
    apply(1'b0, mk_r(1, 1, 0), 1'b0, 1'b1, 1'b1, 32'h1, 32'h2, 32'h300);
    apply(1'b0, mk_r(0, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("no_we", ReadData1, 32'hA5A5A5A5);
    // pc + 4 wraps modulo 2^32
    apply(1'b0, mk_r(3, 0, 0), 1'b1, 1'b0, 1'b1, 0, 0, 32'hFFFF_FFFC);
    apply(1'b0, mk_r(0, 3, 0), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("pc_wrap", ReadData1, 32'h0);

    // Immediate decode
    apply(1'b0, 32'hFFF00093, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("imm_addi", imm32, 32'hFFFFFFFF);
    apply(1'b0, 32'h4030D093, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("imm_srai", imm32, 32'h00000003);
    cmp("f7_srai", {25'h0, funct7}, 32'h20);
    cmp("f3_srai", {29'h0, funct3}, 32'h5);
    apply(1'b0, 32'hFE000EE3, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("imm_beq", imm32, 32'hFFFFFFFC);
    apply(1'b0, 32'h123450B7, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("imm_lui", imm32, 32'h00012345);
    apply(1'b0, 32'hFE512C23, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("imm_sw", imm32, 32'hFFFFFFF8);
    apply(1'b0, 32'h008000EF, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("imm_jal", imm32, 32'h00000008);
    apply(1'b0, 32'h00000033, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("imm_rtype", imm32, 32'h0);

    // Fill every register, reading neighbours as we go
    for (int i = 1; i < 32; i++) begin
      apply(1'b0, mk_r(i, i - 1, 31 - i), 1'b1, 1'b0, 1'b0, 32'h01010101 * i ^ 32'hC0000000, 0, 0);
    end
    apply(1'b0, mk_r(0, 31, 17), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("fill_x31", ReadData1, 32'h1F1F1F1F ^ 32'hC0000000);

    // Reset beats a simultaneous write; mid-program reset restores everything
    apply(1'b1, mk_r(2, 0, 0), 1'b1, 1'b0, 1'b0, 32'h55, 0, 0);
    apply(1'b0, mk_r(0, 2, 7), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("rst_over_wr", ReadData1, 32'h0000_7FFC);
    cmp("rst_clears_x7", ReadData2, 32'h0);

    // Read during write, rs1 = rs2 = rd
    apply(1'b0, mk_r(9, 0, 0), 1'b1, 1'b0, 1'b0, 32'h11, 0, 0);
    apply(1'b0, mk_r(9, 9, 9), 1'b1, 1'b0, 1'b0, 32'h22, 0, 0);
    cmp("rdw_before1", ReadData1, 32'h11);
    cmp("rdw_before2", ReadData2, 32'h11);
    apply(1'b0, mk_r(0, 9, 9), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cmp("rdw_after", ReadData1, 32'h22);

    @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
